// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle between the UART receiver, the frame parser and its consumer.
// The slave side is the parser. The master side is the receiver/consumer environment.
interface uart_frame_parser_if;
   logic       iValid;
   logic [7:0] iData;
   logic [7:0] oData;
   logic       oValid;
   logic       iReady;
   logic       oFrameDone;
   logic       oErrCrc;
   logic       oErrTimeout;
   logic       oOverrun;
   logic       oBusy;

   modport master (
      output iValid, iData, iReady,
      input  oData, oValid, oFrameDone, oErrCrc, oErrTimeout, oOverrun, oBusy
   );

   modport slave (
      input  iValid, iData, iReady,
      output oData, oValid, oFrameDone, oErrCrc, oErrTimeout, oOverrun, oBusy
   );
endinterface

// File: rtl/uart_frame_parser.sv
// Hunts a two-byte sync header in the UART byte stream, collects and checksums a fixed-length
// payload, then replays it over a valid/ready stream; flags CRC, timeout and overrun events.
module uart_frame_parser #(
   parameter logic [7:0] SYNC0       = 8'hA5,
   parameter logic [7:0] SYNC1       = 8'h5A,
   parameter int         PAYLOAD_LEN = 8,
   parameter int         TIMEOUT     = 5000
) (
   input  logic               clk,
   input  logic               rst,
   uart_frame_parser_if.slave bus
);

   localparam int IDX_W = $clog2(PAYLOAD_LEN) + 1;
   localparam int AW    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam int TMR_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {HUNT, SYNC, PAYLOAD, CHECK, DRAIN} stateT;

   stateT            state, stateNext;
   logic             validP1;
   logic             accept;
   logic             timed;
   logic             bufWr;
   logic [IDX_W-1:0] idx, idxNext;
   logic [IDX_W-1:0] rd, rdNext;
   logic [7:0]       sum, sumNext;
   logic [TMR_W-1:0] timer, timerNext;
   logic             frameDone, frameDoneNext;
   logic             errCrc, errCrcNext;
   logic             errTimeout, errTimeoutNext;
   logic             overrun, overrunNext;
   logic [7:0]       payloadBuf [PAYLOAD_LEN];

   function automatic logic [7:0] sumAdd(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   // A byte is taken only on the rising edge of the receiver's level-valid.
   assign accept = bus.iValid && !validP1;
   assign timed  = (state == SYNC) || (state == PAYLOAD) || (state == CHECK);

   always_comb begin
      stateNext      = state;
      idxNext        = idx;
      rdNext         = rd;
      sumNext        = sum;
      timerNext      = '0;
      bufWr          = 1'b0;
      frameDoneNext  = 1'b0;
      errCrcNext     = 1'b0;
      errTimeoutNext = 1'b0;
      overrunNext    = 1'b0;

      case (state)
         HUNT: begin
            if (accept && bus.iData == SYNC0) stateNext = SYNC;
         end
         SYNC: begin
            if (accept) begin
               if (bus.iData == SYNC1) begin
                  stateNext = PAYLOAD;
                  idxNext   = '0;
                  sumNext   = 8'h00;
               end else if (bus.iData != SYNC0) begin
                  stateNext = HUNT;
               end
            end
         end
         PAYLOAD: begin
            if (accept) begin
               bufWr   = 1'b1;
               sumNext = sumAdd(sum, bus.iData);
               idxNext = idx + 1'b1;
               if (idx == IDX_W'(PAYLOAD_LEN - 1)) stateNext = CHECK;
            end
         end
         CHECK: begin
            if (accept) begin
               if (sumAdd(sum, bus.iData) == 8'h00) begin
                  stateNext = DRAIN;
                  rdNext    = '0;
               end else begin
                  errCrcNext = 1'b1;
                  stateNext  = HUNT;
               end
            end
         end
         DRAIN: begin
            if (accept) overrunNext = 1'b1;
            if (bus.iReady) begin
               if (rd == IDX_W'(PAYLOAD_LEN - 1)) begin
                  frameDoneNext = 1'b1;
                  stateNext     = HUNT;
               end else begin
                  rdNext = rd + 1'b1;
               end
            end
         end
         default: stateNext = HUNT;
      endcase

      // An accept in the same cycle always wins; the pulse lands TIMEOUT cycles after the last accept.
      if (timed && !accept) begin
         if (timer == TMR_W'(TIMEOUT - 2)) begin
            errTimeoutNext = 1'b1;
            stateNext      = HUNT;
         end else begin
            timerNext = timer + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= HUNT;
         validP1    <= 1'b0;
         idx        <= '0;
         rd         <= '0;
         sum        <= 8'h00;
         timer      <= '0;
         frameDone  <= 1'b0;
         errCrc     <= 1'b0;
         errTimeout <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= stateNext;
         validP1    <= bus.iValid;
         idx        <= idxNext;
         rd         <= rdNext;
         sum        <= sumNext;
         timer      <= timerNext;
         frameDone  <= frameDoneNext;
         errCrc     <= errCrcNext;
         errTimeout <= errTimeoutNext;
         overrun    <= overrunNext;
      end
   end

   always_ff @(posedge clk) begin
      if (bufWr) payloadBuf[idx[AW-1:0]] <= bus.iData;
   end

   assign bus.oValid      = (state == DRAIN);
   assign bus.oData       = (state == DRAIN) ? payloadBuf[rd[AW-1:0]] : 8'h00;
   assign bus.oBusy       = (state != HUNT);
   assign bus.oFrameDone  = frameDone;
   assign bus.oErrCrc     = errCrc;
   assign bus.oErrTimeout = errTimeout;
   assign bus.oOverrun    = overrun;

endmodule
